alu_exec_unit: RTL

//  Parametrised, handshaked successor to the combinational ALU-control decoder.
//  - Decodes ALU_OP/funct_ctrl into the internal ALU function code.
//  - Executes the operation on DATA_W-bit operands.
//  - SRL runs as a multi-cycle iterative shifter.
//  - Sits between ID/EX and MEM of the multi-cycle datapath; valid/ready on both sides.

---
 rtl/alu_exec_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execute stage: decodes alu_op/funct_ctrl and produces one registered result.
// SRL runs iteratively, shifting at most SHIFT_STEP bits per cycle.
module alu_exec_unit #(
  parameter int DATA_W     = 32,
  parameter int SHAMT_W    = 5,
  parameter int SHIFT_STEP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [5:0]         funct_ctrl,
  input  logic [DATA_W-1:0]  src_a,
  input  logic [DATA_W-1:0]  src_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic [5:0]         funct,
  output logic               zero,
  output logic               illegal
);

  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_ADDU = 6'b001001;
  localparam logic [5:0] F_SUBU = 6'b001010;
  localparam logic [5:0] F_OR   = 6'b010010;
  localparam logic [5:0] F_SRL  = 6'b100010;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    acc_p1, acc_nxt;
  logic [SHAMT_W-1:0]   cnt_p1, cnt_nxt, step_k;
  logic [DATA_W-1:0]    result_p1;
  logic [5:0]           funct_p1;
  logic                 zero_p1, illegal_p1;
  logic                 dec_illegal;
  logic [5:0]           dec_funct;
  logic [DATA_W-1:0]    exec_res;
  logic                 accept, start_shift, shift_last;

  // Returns {illegal, funct}; unknown codes map to funct 000000.
  function automatic logic [6:0] decode(input logic [1:0] op, input logic [5:0] fc);
    logic [6:0] d;
    d = {1'b1, F_NONE};
    case (op)
      2'b00: d = {1'b0, F_ADDU};
      2'b01: d = {1'b0, F_SUBU};
      2'b10: begin
        case (fc)
          6'b001011: d = {1'b0, F_ADDU};
          6'b001101: d = {1'b0, F_SUBU};
          6'b100101: d = {1'b0, F_OR};
          6'b000010: d = {1'b0, F_SRL};
          default:   d = {1'b1, F_NONE};
        endcase
      end
      default: d = {1'b1, F_NONE};
    endcase
    return d;
  endfunction

  // Single-cycle ops; SRL here only covers the shamt=0 pass-through.
  function automatic logic [DATA_W-1:0] execute(input logic [5:0] f,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    case (f)
      F_ADDU:  r = a + b;
      F_SUBU:  r = a - b;
      F_OR:    r = a | b;
      F_SRL:   r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign {dec_illegal, dec_funct} = decode(alu_op, funct_ctrl);
  assign exec_res    = execute(dec_funct, src_a, src_b);
  assign start_shift = !dec_illegal && (dec_funct == F_SRL) && (shamt != '0);

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);

  always_comb begin
    if (int'(cnt_p1) < SHIFT_STEP) step_k = cnt_p1;
    else                           step_k = SHAMT_W'(SHIFT_STEP);
  end

  assign acc_nxt    = acc_p1 >> step_k;
  assign cnt_nxt    = cnt_p1 - step_k;
  assign shift_last = (cnt_nxt == '0) || (acc_nxt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      SHIFT:   if (shift_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) state_d = start_shift ? SHIFT : DONE;
  end

  // Stage p1: operand latch / shift iteration / registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1     <= '0;
      cnt_p1     <= '0;
      result_p1  <= '0;
      funct_p1   <= '0;
      zero_p1    <= 1'b0;
      illegal_p1 <= 1'b0;
    end else if (accept) begin
      acc_p1 <= src_b;
      cnt_p1 <= shamt;
      if (!start_shift) begin
        result_p1  <= exec_res;
        funct_p1   <= dec_funct;
        zero_p1    <= (exec_res == '0);
        illegal_p1 <= dec_illegal;
      end
    end else if (state_q == SHIFT) begin
      acc_p1 <= acc_nxt;
      cnt_p1 <= cnt_nxt;
      if (shift_last) begin
        result_p1  <= acc_nxt;
        funct_p1   <= F_SRL;
        zero_p1    <= (acc_nxt == '0);
        illegal_p1 <= 1'b0;
      end
    end
  end

  assign result  = result_p1;
  assign funct   = funct_p1;
  assign zero    = zero_p1;
  assign illegal = illegal_p1;

endmodule
